// File: rtl/ahb_apb4_bridge_pkg.sv
// Shared types, bus encodings and helpers for the AHB-Lite to APB4 bridge.
package ahb_apb4_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DPHASE,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int MAX_SLAVES = 16;
  localparam int MAX_ADDR_W = 64;

  // Default map: slave i owns the 256-byte window at i*'h100.
  function automatic logic [MAX_SLAVES*MAX_ADDR_W-1:0] default_base(input int aw);
    logic [MAX_SLAVES*MAX_ADDR_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_SLAVES; i++)
      v[i*aw +: MAX_ADDR_W] = MAX_ADDR_W'(i * 256);
    return v;
  endfunction

  function automatic logic [MAX_SLAVES*MAX_ADDR_W-1:0] default_mask(input int aw);
    logic [MAX_SLAVES*MAX_ADDR_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_SLAVES; i++)
      v[i*aw +: MAX_ADDR_W] = ~MAX_ADDR_W'(8'hFF);
    return v;
  endfunction

  // Byte-lane strobes for a transfer of 2**size bytes at the given lane offset.
  function automatic logic [7:0] gen_strb(input logic [2:0] size, input logic [2:0] lsb,
                                          input int nbytes);
    logic [15:0] m;
    m = (16'd1 << (4'd1 << size)) - 16'd1;
    m = m << (lsb & 3'(nbytes - 1));
    return m[7:0];
  endfunction

endpackage

// File: rtl/ahb_apb4_bridge_decoder.sv
// Base/mask address decoder producing a one-hot APB select and a miss flag.
module apb_addr_decoder #(
  parameter int ADDR_W       = 32,
  parameter int NO_OF_SLAVES = 8,
  parameter logic [NO_OF_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NO_OF_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_W-1:0]       addr,
  output logic [NO_OF_SLAVES-1:0] sel,
  output logic                    miss
);

  // Walk from the top so the lowest matching index is the one that survives.
  always_comb begin
    sel = '0;
    for (int i = NO_OF_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
    miss = ~|sel;
  end

endmodule

// File: rtl/ahb_apb4_bridge.sv
// AHB-Lite slave to APB4 master bridge with registered outputs, size checks and PREADY timeout.
module ahb_apb4_bridge
  import ahb_apb4_bridge_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int NO_OF_SLAVES = 8,
  parameter logic [NO_OF_SLAVES*ADDR_W-1:0] SLAVE_BASE =
    (NO_OF_SLAVES*ADDR_W)'(default_base(ADDR_W)),
  parameter logic [NO_OF_SLAVES*ADDR_W-1:0] SLAVE_MASK =
    (NO_OF_SLAVES*ADDR_W)'(default_mask(ADDR_W)),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic                           HSEL,
  input  logic [ADDR_W-1:0]              HADDR,
  input  logic [1:0]                     HTRANS,
  input  logic                           HWRITE,
  input  logic [2:0]                     HSIZE,
  input  logic [3:0]                     HPROT,
  input  logic [DATA_W-1:0]              HWDATA,
  input  logic                           HREADY,
  output logic                           HREADYOUT,
  output logic                           HRESP,
  output logic [DATA_W-1:0]              HRDATA,
  output logic [ADDR_W-1:0]              PADDR,
  output logic                           PWRITE,
  output logic [DATA_W-1:0]              PWDATA,
  output logic [DATA_W/8-1:0]            PSTRB,
  output logic [2:0]                     PPROT,
  output logic [NO_OF_SLAVES-1:0]        PSEL,
  output logic                           PENABLE,
  input  logic [NO_OF_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NO_OF_SLAVES-1:0]        PREADY,
  input  logic [NO_OF_SLAVES-1:0]        PSLVERR
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int SIZE_MAX = $clog2(STRB_W);
  localparam int TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t state_q, state_d;

  logic                    accept, dec_miss, size_err, sel_ready, sel_err, timeout;
  logic [NO_OF_SLAVES-1:0] dec_sel, sel_l;
  logic [ADDR_W-1:0]       addr_l;
  logic                    write_l;
  logic [2:0]              size_l;
  logic [1:0]              prot_l;
  logic [TO_W-1:0]         to_cnt;
  logic [DATA_W-1:0]       rdata_sel;
  logic [7:0]              strb8;
  logic                    prot_unused, strb_unused;

  logic                    hreadyout_d, hresp_d, pwrite_d, penable_d;
  logic [DATA_W-1:0]       hrdata_d, pwdata_d;
  logic [ADDR_W-1:0]       paddr_d;
  logic [STRB_W-1:0]       pstrb_d;
  logic [2:0]              pprot_d;
  logic [NO_OF_SLAVES-1:0] psel_d;

  apb_addr_decoder #(
    .ADDR_W      (ADDR_W),
    .NO_OF_SLAVES(NO_OF_SLAVES),
    .SLAVE_BASE  (SLAVE_BASE),
    .SLAVE_MASK  (SLAVE_MASK)
  ) u_dec (
    .addr(HADDR),
    .sel (dec_sel),
    .miss(dec_miss)
  );

  // A new transfer is only taken while no APB access is outstanding.
  assign accept    = HSEL && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ) && HREADY &&
                     (state_q == ST_IDLE || state_q == ST_ERR2);
  assign size_err  = HSIZE > 3'(SIZE_MAX);
  assign sel_ready = |(PREADY & PSEL);
  assign sel_err   = |(PSLVERR & PSEL);
  assign timeout   = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign strb8     = gen_strb(size_l, addr_l[2:0], STRB_W);
  assign prot_unused = ^HPROT[3:2];
  assign strb_unused = ^strb8;

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++)
      if (PSEL[i]) rdata_sel = rdata_sel | PRDATA[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      HRDATA    <= '0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
    end else begin
      state_q   <= state_d;
      HREADYOUT <= hreadyout_d;
      HRESP     <= hresp_d;
      HRDATA    <= hrdata_d;
      PADDR     <= paddr_d;
      PWRITE    <= pwrite_d;
      PWDATA    <= pwdata_d;
      PSTRB     <= pstrb_d;
      PPROT     <= pprot_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (accept) state_d = (dec_miss || size_err) ? ST_ERR1 : ST_DPHASE;
        else        state_d = ST_IDLE;
      end
      ST_DPHASE: state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (sel_ready)    state_d = sel_err ? ST_ERR1 : ST_IDLE;
        else if (timeout) state_d = ST_ERR1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hreadyout_d = HREADYOUT;
    hresp_d     = HRESP;
    hrdata_d    = HRDATA;
    paddr_d     = PADDR;
    pwrite_d    = PWRITE;
    pwdata_d    = PWDATA;
    pstrb_d     = PSTRB;
    pprot_d     = PPROT;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        hreadyout_d = !accept;
        hresp_d     = accept && (dec_miss || size_err);
      end
      ST_DPHASE: begin
        paddr_d     = addr_l;
        pwrite_d    = write_l;
        pwdata_d    = write_l ? HWDATA : '0;
        pstrb_d     = write_l ? strb8[STRB_W-1:0] : '0;
        pprot_d     = {~prot_l[0], 1'b0, prot_l[1]};
        psel_d      = sel_l;
        penable_d   = 1'b0;
        hreadyout_d = 1'b0;
      end
      ST_SETUP: penable_d = 1'b1;
      ST_ACCESS: begin
        if (sel_ready || timeout) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          hreadyout_d = sel_ready && !sel_err;
          hresp_d     = !(sel_ready && !sel_err);
          if (sel_ready && !sel_err && !write_l) hrdata_d = rdata_sel;
        end
      end
      ST_ERR1: begin
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_ERROR;
      end
      default: ;
    endcase
  end

  // Address-phase capture and wait-state counting; no reset needed on these.
  always_ff @(posedge HCLK) begin
    if (accept) begin
      addr_l  <= HADDR;
      write_l <= HWRITE;
      size_l  <= HSIZE;
      prot_l  <= HPROT[1:0];
      sel_l   <= dec_sel;
    end
    if (state_q == ST_SETUP)                    to_cnt <= '0;
    else if (state_q == ST_ACCESS && !sel_ready) to_cnt <= to_cnt + TO_W'(1);
  end

endmodule

// File: tb/tb_ahb_apb4_bridge.sv
// Directed bench for ahb_apb4_bridge with a transaction-level reference and per-cycle compare.
module tb_ahb_apb4_bridge;

  localparam int TO = 16;

  logic         HCLK = 1'b0;
  logic         HRESET, HSEL, HWRITE, HREADY;
  logic [31:0]  HADDR, HWDATA;
  logic [1:0]   HTRANS;
  logic [2:0]   HSIZE;
  logic [3:0]   HPROT;
  logic         HREADYOUT, HRESP, PWRITE, PENABLE;
  logic [31:0]  HRDATA, PADDR, PWDATA;
  logic [3:0]   PSTRB;
  logic [2:0]   PPROT;
  logic [7:0]   PSEL, PREADY, PSLVERR;
  logic [255:0] PRDATA;

  ahb_apb4_bridge #(
    .ADDR_W(32), .DATA_W(32), .NO_OF_SLAVES(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  int n_chk = 0;
  int n_pass = 0;

  logic        chk_en = 1'b0;
  logic        exp_hro, exp_hresp, exp_pen, exp_apb, exp_pwrite;
  logic [7:0]  exp_psel;
  logic [31:0] exp_hrdata, exp_paddr, exp_pwdata;
  logic [3:0]  exp_pstrb;
  logic [2:0]  exp_pprot;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: slave i owns [i*256, i*256+255], eight slaves.
  function automatic logic [7:0] m_sel(input logic [31:0] a);
    logic [31:0] idx;
    idx = a >> 8;
    if (idx < 8) return 8'(1) << idx[2:0];
    return 8'h00;
  endfunction

  function automatic logic [3:0] m_strb(input logic [31:0] a, input logic w, input logic [2:0] sz);
    int nb, m;
    if (!w) return 4'h0;
    nb = 1 << sz;
    m  = ((1 << nb) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [2:0] m_pprot(input logic [3:0] p);
    return 3'((p[0] ? 0 : 4) + (p[1] ? 1 : 0));
  endfunction

  always @(negedge HCLK) begin
    if (chk_en) begin
      check("hreadyout", 64'(HREADYOUT), 64'(exp_hro));
      check("hresp",     64'(HRESP),     64'(exp_hresp));
      check("psel",      64'(PSEL),      64'(exp_psel));
      check("penable",   64'(PENABLE),   64'(exp_pen));
      check("hrdata",    64'(HRDATA),    64'(exp_hrdata));
      if (exp_apb) begin
        check("paddr",  64'(PADDR),  64'(exp_paddr));
        check("pwrite", 64'(PWRITE), 64'(exp_pwrite));
        check("pwdata", 64'(PWDATA), 64'(exp_pwdata));
        check("pstrb",  64'(PSTRB),  64'(exp_pstrb));
        check("pprot",  64'(PPROT),  64'(exp_pprot));
      end
    end
  end

  // One AHB transfer; nwait >= TO means the selected slave never becomes ready.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [3:0] prot, input logic [31:0] wd, input int nwait,
                      input logic serr, input logic [31:0] rd);
    logic [7:0] s;
    logic       aerr, to;
    int         done_t, len;
    s      = m_sel(a);
    aerr   = (s == 8'h00) || (sz > 3'd2);
    to     = (nwait >= TO);
    done_t = to ? (3 + TO) : (4 + nwait);
    len    = aerr ? 3 : done_t + 2;
    exp_paddr  = a;
    exp_pwrite = w;
    exp_pwdata = w ? wd : 32'h0;
    exp_pstrb  = m_strb(a, w, sz);
    exp_pprot  = m_pprot(prot);
    for (int i = 0; i < 8; i++) PRDATA[i*32 +: 32] = s[i] ? rd : (32'hA5A5_0000 + 32'(i));
    HSEL = 1'b1; HADDR = a; HTRANS = 2'b10; HWRITE = w; HSIZE = sz; HPROT = prot;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h0000_0104; HWDATA = wd;
    for (int t = 1; t <= len; t++) begin
      exp_apb = 1'b0; exp_pen = 1'b0; exp_psel = 8'h00;
      if (aerr) begin
        exp_hro   = (t >= 2);
        exp_hresp = (t <= 2);
      end else if (t < done_t) begin
        exp_hro = 1'b0; exp_hresp = 1'b0;
        if (t >= 2) begin exp_psel = s; exp_apb = 1'b1; exp_pen = (t >= 3); end
      end else if (t == done_t) begin
        exp_hro   = !(to || serr);
        exp_hresp = to || serr;
        if (!w && !to && !serr) exp_hrdata = rd;
      end else if (t == done_t + 1 && (to || serr)) begin
        exp_hro = 1'b1; exp_hresp = 1'b1;
      end else begin
        exp_hro = 1'b1; exp_hresp = 1'b0;
      end
      if (!aerr && !to && t == 3 + nwait) begin
        PREADY = 8'hFF; PSLVERR = serr ? 8'hFF : ~s;
      end else begin
        PREADY = ~s; PSLVERR = ~s;
      end
      chk_en = 1'b1;
      @(posedge HCLK); #1;
      HWDATA = 32'h0BAD_F00D;
    end
    chk_en = 1'b0;
  endtask

  // Cycles in which the bridge must stay idle; inputs offered before the call get one edge.
  task automatic idle_cycles(input int n);
    exp_hro = 1'b1; exp_hresp = 1'b0; exp_psel = 8'h00; exp_pen = 1'b0; exp_apb = 1'b0;
    for (int t = 0; t < n; t++) begin
      chk_en = 1'b1;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1;
    end
    chk_en = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hreadyout"}, 64'(HREADYOUT), 64'd1);
    check({tag, "_hresp"},     64'(HRESP),     64'd0);
    check({tag, "_psel"},      64'(PSEL),      64'd0);
    check({tag, "_penable"},   64'(PENABLE),   64'd0);
    check({tag, "_paddr"},     64'(PADDR),     64'd0);
    check({tag, "_pwdata"},    64'(PWDATA),    64'd0);
    check({tag, "_pstrb"},     64'(PSTRB),     64'd0);
    check({tag, "_hrdata"},    64'(HRDATA),    64'd0);
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd2;
    HPROT = 4'h0; HWDATA = '0; HREADY = 1'b1; PRDATA = '0; PREADY = '0; PSLVERR = '0;
    exp_hrdata = 32'h0;
    @(posedge HCLK); @(posedge HCLK); #1;
    check_reset_vals("reset");
    HRESET = 1'b0;

    check("pin_sel_104",  64'(m_sel(32'h104)),          64'h02);
    check("pin_sel_302",  64'(m_sel(32'h302)),          64'h08);
    check("pin_sel_900",  64'(m_sel(32'h900)),          64'h00);
    check("pin_strb_203", 64'(m_strb(32'h203, 1, 0)),   64'h8);
    check("pin_strb_206", 64'(m_strb(32'h206, 1, 1)),   64'hC);
    check("pin_strb_104", 64'(m_strb(32'h104, 1, 2)),   64'hF);
    check("pin_pprot",    64'(m_pprot(4'b0011)),        64'h1);

    idle_cycles(2);
    xfer(32'h104, 1'b1, 3'd2, 4'b0011, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    xfer(32'h302, 1'b0, 3'd0, 4'b0000, 32'h0, 2, 1'b0, 32'h1122_3344);
    check("read_hrdata_literal", 64'(HRDATA), 64'h1122_3344);
    xfer(32'h203, 1'b1, 3'd0, 4'b0001, 32'h5500_0000, 0, 1'b0, 32'h0);
    xfer(32'h206, 1'b1, 3'd1, 4'b0010, 32'h7788_0000, 1, 1'b0, 32'h0);
    xfer(32'h900, 1'b1, 3'd2, 4'b0000, 32'h1234_5678, 0, 1'b0, 32'h0);
    xfer(32'h100, 1'b0, 3'd3, 4'b0000, 32'h0, 0, 1'b0, 32'h0);
    xfer(32'h500, 1'b0, 3'd2, 4'b0000, 32'h0, TO, 1'b0, 32'h0);
    xfer(32'h000, 1'b0, 3'd2, 4'b0000, 32'h0, 0, 1'b1, 32'hFFFF_0000);
    check("slverr_hrdata_kept", 64'(HRDATA), 64'h1122_3344);

    HSEL = 1'b1; HADDR = 32'h104; HTRANS = 2'b10; HWRITE = 1'b1; HREADY = 1'b0;
    idle_cycles(2);
    HSEL = 1'b1; HADDR = 32'h104; HTRANS = 2'b01;
    idle_cycles(2);
    HSEL = 1'b0; HADDR = 32'h104; HTRANS = 2'b10;
    idle_cycles(2);

    // Reset while the APB access is waiting on PREADY.
    PREADY = 8'h00; PSLVERR = 8'h00;
    HSEL = 1'b1; HADDR = 32'h010; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    check("midaccess_penable", 64'(PENABLE), 64'd1);
    check("midaccess_psel",    64'(PSEL),    64'h01);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    check_reset_vals("hreset1");
    @(posedge HCLK); #1;
    check_reset_vals("hreset2");
    HRESET = 1'b0;
    exp_hrdata = 32'h0;
    idle_cycles(2);
    xfer(32'h700, 1'b0, 3'd2, 4'b0010, 32'h0, 1, 1'b0, 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ahb_apb4_bridge.md
Name: ahb_apb4_bridge

Overview:
Parametrised AHB-Lite slave to APB4 master bridge; next generation of the team's AHB-to-APB bridge. Generalises data/address width, slave count and address map (base/mask). Adds APB4 PSTRB/PPROT, a correct two-cycle AHB ERROR response, HREADY-qualified address sampling, HSIZE checking and a PREADY timeout. Sits between the AHB interconnect and the peripheral APB segment.

Parameters:
ADDR_W, 32, address width (HADDR/PADDR)
DATA_W, 32, data width; one of 32 or 64
NO_OF_SLAVES, 8, APB slaves (1..16), one PSEL bit each
SLAVE_BASE, {i*'h100}, packed NO_OF_SLAVES*ADDR_W; base of slave i
SLAVE_MASK, {~'hFF}, packed NO_OF_SLAVES*ADDR_W; slave i hit when (addr & MASK_i) == BASE_i
TIMEOUT_CYCLES, 256, max ACCESS cycles with PREADY low; 0 disables timeout

Ports:
HCLK  in  1  single clock
HRESET  in  1  synchronous, active-high reset
HSEL  in  1  bridge select
HADDR  in  ADDR_W  address-phase address
HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
HWRITE  in  1  write when 1
HSIZE  in  3  transfer size
HPROT  in  4  protection
HWDATA  in  DATA_W  write data (data phase)
HREADY  in  1  bus-wide ready (HREADYIN)
HREADYOUT  out  1  bridge ready
HRESP  out  1  0 OKAY, 1 ERROR
HRDATA  out  DATA_W  read data
PADDR  out  ADDR_W  APB address
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PSTRB  out  DATA_W/8  byte strobes
PPROT  out  3  APB4 protection
PSEL  out  NO_OF_SLAVES  one-hot slave select
PENABLE  out  1  APB access phase
PRDATA  in  NO_OF_SLAVES*DATA_W  packed per-slave read data
PREADY  in  NO_OF_SLAVES  per-slave ready
PSLVERR  in  NO_OF_SLAVES  per-slave error

Behaviour:
- All outputs registered. Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0, PPROT=0, PSEL=0, PENABLE=0, state IDLE.
- HRESET mid-operation: next edge forces reset values; an in-flight APB transfer is abandoned (PSEL/PENABLE drop); no AHB response given.
- Accept = HSEL & HTRANS[1] & HREADY, sampled in IDLE or ERR2 only. On accept latch addr, write, size, prot; decode one-hot select (lowest index wins on overlap).
- BUSY/IDLE HTRANS, or HSEL low: no action, HREADYOUT=1, HRESP=0.
- States: IDLE, DPHASE, SETUP, ACCESS, ERR1, ERR2.
- IDLE/ERR2 on accept: decode miss, or HSIZE > log2(DATA_W/8) -> ERR1; else -> DPHASE.
- DPHASE (HREADYOUT=0): capture HWDATA into PWDATA (writes; reads PWDATA=0); drive PADDR, PWRITE, PPROT, PSTRB, PSEL -> SETUP.
- SETUP: PSEL held, PENABLE=0 -> ACCESS with PENABLE=1.
- ACCESS: sel_ready = |(PREADY & PSEL). On sel_ready: PSEL=0, PENABLE=0. PSLVERR of selected slave -> ERR1; else IDLE with HREADYOUT=1, HRESP=0, and for reads HRDATA=PRDATA slice of selected slave. Timeout counter cleared on ACCESS entry; TIMEOUT_CYCLES consecutive cycles without sel_ready -> PSEL/PENABLE dropped, -> ERR1.
- ERR1: HRESP=1, HREADYOUT=0 -> ERR2. ERR2: HRESP=1, HREADYOUT=1 -> IDLE, or accepts new transfer as above.
- Minimum latency (zero-wait slave): address phase at edge T0 -> HREADYOUT low in T1..T3, high at T4. Each APB wait state adds one cycle.
- PSTRB: writes = ((1<<(1<<HSIZE))-1) << (HADDR mod DATA_W/8); reads = 0.
- PPROT = {~HPROT[0], 1'b0, HPROT[1]}.
- HRDATA holds its value except on successful read completion.

Decomposition:
- Package ahb_apb4_bridge_pkg: state enum; HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3); HRESP constants; strobe-generation function.
- One sub-module apb_addr_decoder: base/mask decode, one-hot select plus miss flag, parametrised by ADDR_W, NO_OF_SLAVES, SLAVE_BASE, SLAVE_MASK.

Test Plan:
- HRESET=1 for 2 cycles mid-ACCESS -> next edge HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0, PADDR=0.
- Zero-wait word write 0x104, HWDATA=0xDEADBEEF -> PSEL=8'b00000010 at T2, PENABLE=1 at T3, PSTRB=4'hF, PWDATA=0xDEADBEEF, HREADYOUT=1 at T4.
- Byte read 0x302, slave 3 PRDATA=0x11223344 with 2 PREADY wait states -> PSTRB=0, HREADYOUT low T1..T5, HRDATA=0x11223344 at T6.
- Byte write 0x203 -> PSEL=8'b00000100, PSTRB=4'b1000; halfword write 0x206 -> PSTRB=4'b1100.
- Unmapped 0x900, then HSIZE=3 on DATA_W=32 -> PSEL never asserted; HRESP=1/HREADYOUT=0 at T1, HRESP=1/HREADYOUT=1 at T2.
- TIMEOUT_CYCLES=16 with PREADY stuck low -> PSEL drops after 16 ACCESS cycles, then two-cycle ERROR. PSLVERR=1 with PREADY on slave 0 -> two-cycle ERROR, HRDATA unchanged.
